// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package addsub_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk-index width: clog2 of the chunk count, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operation request / result handshake bundle for addsub_serial.
interface addsub_serial_if
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its MSB.
module addsub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    // Ripple chain of full-adder cells.
    for (genvar g = 0; g < CHUNK; g++) begin : g_bit
        full_adder u_fa (
            .i_a (i_a[g]),
            .i_b (i_b[g]),
            .i_c (w_c[g]),
            .o_s (o_sum[g]),
            .o_c (w_c[g+1])
        );
    end

    assign o_cout = w_c[CHUNK];
    assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: one shared CHUNK-bit slice, WIDTH/CHUNK cycles per op.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic            clk,
    input  logic            rst,
    addsub_serial_if.slave  bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_op;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] w_sum_nxt;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_chunk_cmsb;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_is_sub;

    assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_last     = (r_idx == IDXW'(NCHUNK - 1));
    assign w_is_sub   = (bus.op == OP_SUB);

    // Select the active operand chunks and splice the new chunk result into the sum.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        w_sum_nxt = r_sum;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_chunk                   = r_a[i*CHUNK +: CHUNK];
                w_b_chunk                   = r_b[i*CHUNK +: CHUNK];
                w_sum_nxt[i*CHUNK +: CHUNK] = w_chunk_sum;
            end
        end
    end

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout),
        .o_cmsb (w_chunk_cmsb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE can go straight back to RUN when a new op is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch on accept; one slice step per RUN cycle; flags captured on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + ~borrow_in, so invert B and the incoming carry.
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{w_is_sub}};
            r_op    <= bus.op;
            r_carry <= bus.cin ^ w_is_sub;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_chunk_cout;
            if (w_last) begin
                r_cout <= w_chunk_cout ^ r_op;
                r_ovf  <= w_chunk_cmsb ^ w_chunk_cout;
                r_zero <= (w_sum_nxt == '0);
            end else begin
                r_idx  <= r_idx + IDXW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, CHUNK=4).
module tb_addsub_serial;
    import addsub_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int          TCLK   = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #(TCLK/2) clk = ~clk;

    addsub_serial_if #(.WIDTH(WIDTH)) bus ();

    addsub_serial #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t exp_q[$];
    time  acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: exact integer arithmetic, then wrap and range-check.
    function automatic res_t model(input logic op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        res_t r;
        int ua, ub, us, sa, sb, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op == OP_ADD) begin
            us     = ua + ub + int'(cin);
            ss     = sa + sb + int'(cin);
            r.cout = (us > 65535);
        end else begin
            us     = ua - ub - int'(cin);
            ss     = sa - sb - int'(cin);
            r.cout = (us < 0);
        end
        r.sum  = 16'(us);
        r.ovf  = (ss > 32767) || (ss < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record every accepted operation with its expected result.
    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.op, bus.a, bus.b, bus.cin));
            acc_q.push_back($time);
        end
    end

    // Compare outputs against the model on every cycle a result is presented.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    if (!prev_ov)
                        chk("latency", 32'($time - acc_q[0]), 32'(NCHUNK*TCLK + TCLK/2));
                    chk("sum",  32'(bus.sum),  32'(exp_q[0].sum));
                    chk("cout", 32'(bus.cout), 32'(exp_q[0].cout));
                    chk("ovf",  32'(bus.ovf),  32'(exp_q[0].ovf));
                    chk("zero", 32'(bus.zero), 32'(exp_q[0].zero));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output time t_acc);
        logic rdy;
        logic got;
        got          = 1'b0;
        t_acc        = 0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        for (int i = 0; i < 64; i++) begin
            #2;
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                got   = 1'b1;
                t_acc = $time - 1;
                break;
            end
        end
        chk("accept_timeout", 32'(got), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("valid_timeout", 32'(got), 32'd1);
    endtask

    // One operation with hand-computed expectations, held in DONE for one cycle first.
    task automatic directed(input string name, input logic op, input logic [15:0] a,
                            input logic [15:0] b, input logic cin, input logic [15:0] e_sum,
                            input logic e_cout, input logic e_ovf, input logic e_zero);
        time t_acc;
        bus.out_ready = 1'b0;
        send(op, a, b, cin, t_acc);
        wait_valid();
        chk({name, "_lat"},  32'($time - 1 - t_acc), 32'(NCHUNK*TCLK));
        chk({name, "_sum"},  32'(bus.sum),  32'(e_sum));
        chk({name, "_cout"}, 32'(bus.cout), 32'(e_cout));
        chk({name, "_ovf"},  32'(bus.ovf),  32'(e_ovf));
        chk({name, "_zero"}, 32'(bus.zero), 32'(e_zero));
        bus.out_ready = 1'b1;
        tick();
        chk({name, "_release"}, 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        time t_acc;
        time t_prev;

        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed arithmetic vectors.
        directed("add_carry_nibble", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        directed("add_wrap",         OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",          OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf",          OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("sub_borrow",       OP_SUB, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        directed("sub_bin",          OP_SUB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        directed("add_zero",         OP_ADD, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Back-pressure: result held, new requests refused, then accept and release together.
        bus.out_ready = 1'b0;
        send(OP_ADD, 16'h1111, 16'h2222, 1'b0, t_acc);
        wait_valid();
        bus.in_valid = 1'b1;
        bus.op       = OP_SUB;
        bus.a        = 16'hABCD;
        bus.b        = 16'h1234;
        bus.cin      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_sum",       32'(bus.sum),       32'h3333);
            tick();
        end
        bus.out_ready = 1'b1;
        #2;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        wait_valid();
        chk("bp_second_sum",  32'(bus.sum),  32'h9999);
        chk("bp_second_cout", 32'(bus.cout), 32'd0);

        // Back-to-back with out_ready held high: one accept every NCHUNK+1 cycles.
        bus.out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 8; k++) begin
            send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), t_acc);
            if (k > 0)
                chk("b2b_spacing", 32'(t_acc - t_prev), 32'((NCHUNK + 1) * TCLK));
            t_prev = t_acc;
        end
        drain();

        directed("add_all_flags", OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Reset two cycles into RUN aborts the operation.
        bus.out_ready = 1'b1;
        send(OP_ADD, 16'h1234, 16'h0FFF, 1'b0, t_acc);
        tick();
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum",       32'(bus.sum),       32'd0);
        chk("mid_rst_cout",      32'(bus.cout),      32'd0);
        chk("mid_rst_ovf",       32'(bus.ovf),       32'd0);
        chk("mid_rst_zero",      32'(bus.zero),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        directed("post_rst_add", OP_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per cycle through one shared CHUNK-bit ripple-carry slice, with a registered carry between slices. It replaces fixed-width combinational adders wherever area matters more than latency. It adds a subtract mode, carry/borrow in and out, signed-overflow and zero flags, and valid/ready handshakes on both input and output.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  1  0 = add (A+B+cin), 1 = subtract (A−B−cin).
- a  in  WIDTH  augend/minuend.
- b  in  WIDTH  addend/subtrahend.
- cin  in  1  carry-in for add; borrow-in for subtract.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out for add; borrow-out for subtract.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE after chunk NCHUNK−1 is processed.
  - DONE → IDLE on out_valid & out_ready, or DONE → RUN if a new operation is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Inputs are ignored while in_ready is 0.
- On accept, the block latches a, b ^ {WIDTH{op}}, and op, and initialises the carry register to cin ^ op. It also clears the chunk index and the sum register.
- Each RUN cycle, the block computes chunk idx as a[idx] + b'[idx] + carry. It writes that result into sum[idx*CHUNK +: CHUNK], updates the carry register, and increments idx.
- On the last chunk, the block also captures:
  - cout = carry_out ^ op;
  - ovf = carry into the MSB ^ carry out of the MSB.
- zero is derived from the final sum register.
- In DONE, sum/cout/ovf/zero are stable while out_valid & !out_ready.
- Reset values: state IDLE; in_ready 1; out_valid 0; sum 0; cout 0; ovf 0; zero 0; carry 0; idx 0.
- Reset mid-operation aborts the operation. No result is produced for it.

## Timing
- An operation accepted at edge T has RUN active during cycles T..T+NCHUNK−1. out_valid rises after edge T+NCHUNK, giving NCHUNK cycles of latency; with the defaults this is 4.
- Minimum period between accepts is NCHUNK+1 cycles, achieved when out_ready is held high (DONE→RUN overlap).
- The index runs 0..NCHUNK−1 with no wrap-around. The chunk-index width is clog2(NCHUNK), minimum 1.
- The NCHUNK==1 degenerate case must work: RUN lasts 1 cycle.
- out_valid deasserts on the edge where the handshake completes, unless a new result lands that same edge; by construction it cannot land, because RUN ≥ 1 cycle.

## Structure
- Shared package addsub_pkg holds:
  - the state enum;
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module addsub_chunk: combinational CHUNK-bit ripple slice built from the existing full_adder cell. Its outputs are sum, carry-out, and the carry into its MSB, which is used for ovf.
- The top level contains the FSM, operand registers, carry register, index counter and result register. It holds no arithmetic beyond the single addsub_chunk instance.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Add 0x00FF + 0x0001, cin 0 → sum 0x0100, cout 0, ovf 0, zero 0, out_valid exactly 4 cycles after accept.
- Add 0xFFFF + 0x0001, cin 0 → sum 0x0000, cout 1, ovf 0, zero 1. Add 0x7FFF + 0x0001 → 0x8000, ovf 1.
- Sub 0x8000 − 0x0001 → 0x7FFF, cout 0, ovf 1. Sub 0x0001 − 0x0002 → 0xFFFF, cout (borrow) 1. Sub 5 − 3 with cin 1 → 0x0001.
- Back-pressure: hold out_ready 0 for 10 cycles in DONE → outputs stable, in_ready 0, new in_valid ignored. Then raise out_ready with in_valid high → accept and release on the same edge.
- Back-to-back with out_ready tied high: 8 random operations → accept every 5 cycles, all results match the reference model.
- Assert rst 2 cycles into RUN → all outputs return to reset values immediately; after release, in_ready=1 and the next operation computes correctly.
